adc_frame_packer: RTL and testbench
===================================

ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 Parameter: FRAME_LEN, 1024, samples per output frame; power of two, 4..65536.
REQ-002 Ports:
- CLK  in  1  sole clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  capture enable, level-sensitive.
- s_axis_tdata  in  16  XADC sample; 12-bit unipolar code in [15:4], [3:0] ignored.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  FFT input word; [15:0] real, [31:16] imag.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last sample of a frame.
- frame_count  out  16  completed frames, wraps modulo 2^16.
- busy  out  1  high in RUN or STOP.

Function
REQ-003 Input transfer occurs on a CLK edge with s_axis_tvalid=1 and s_axis_tready=1; output transfer on an edge with m_axis_tvalid=1 and m_axis_tready=1.
REQ-004 Conversion: code = s_axis_tdata[15:4]; real = {4 copies of ~code[11], ~code[11], code[10:0]} (offset-binary to two's complement, sign-extended); imag = 16'h0000.
- Examples: 16'h0000->real 16'hF800; 16'h8000->16'h0000; 16'hFFF0->16'h07FF.
REQ-005 FSM states IDLE, RUN, STOP; reset state IDLE.
REQ-006 IDLE: s_axis_tready=1; accepted samples discarded; no output; IDLE->RUN when EN=1 (sampled on edge), sample counter cleared.
REQ-007 RUN: each accepted sample is converted and written to a 2-entry output FIFO; sample counter increments per accepted sample, wraps at FRAME_LEN.
REQ-008 RUN->STOP when EN=0 and sample counter !=0; RUN->IDLE when EN=0 and sample counter ==0 (frame boundary).
REQ-009 STOP: samples still accepted and packed; ->IDLE on the edge accepting sample index FRAME_LEN-1; EN re-asserted during STOP has no effect until IDLE reached.
REQ-010 Output frame always contains exactly FRAME_LEN samples; partial frames never emitted.
REQ-011 m_axis_tlast=1 exactly on the entry holding sample index FRAME_LEN-1; tlast is stored with data in FIFO.
REQ-012 s_axis_tready in RUN/STOP = 1 when FIFO holds 0 entries, or 1 entry, or 2 entries with an output transfer this cycle is NOT permitted: tready SHALL be a registered function of FIFO occupancy (tready=1 iff occupancy after current edge <2); no combinational path m_axis_tready->s_axis_tready.
REQ-013 Latency: sample accepted on edge N is visible on m_axis_tdata after edge N (registered), if FIFO was empty.
REQ-014 m_axis_tdata/tlast held stable while m_axis_tvalid=1 and m_axis_tready=0; m_axis_tvalid never drops without transfer.
REQ-015 FIFO simultaneous push and pop: occupancy unchanged, order preserved; push when full never occurs (guaranteed by REQ-012).
REQ-016 frame_count increments on the output transfer carrying tlast; 16'hFFFF wraps to 0.
REQ-017 Transition RUN/STOP->IDLE does not flush FIFO; remaining entries drain normally in IDLE.
REQ-018 busy = (state!=IDLE).

Reset
REQ-019 RST=1 asynchronously: state=IDLE, sample counter=0, FIFO empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=1, frame_count=0, busy=0.
REQ-020 RST mid-frame discards partial frame and FIFO contents; first frame after release starts at sample index 0.

Verification
REQ-021 FRAME_LEN=8, EN=1, tvalid/tready always 1, codes 0..7 <<4 -> outputs 16'hF800..16'hF807, tlast on 8th, frame_count=1.
REQ-022 Conversion sweep: inputs 16'h0000, 16'h8000, 16'hFFF0, 16'h7FFF -> real 16'hF800, 16'h0000, 16'h07FF, 16'hFFFF; imag 0.
REQ-023 m_axis_tready=0 for 10 cycles mid-frame -> s_axis_tready=0 after 2 stored entries, no sample lost or duplicated, data stable.
REQ-024 FRAME_LEN=8, EN dropped after sample 3 -> STOP, samples 4..7 still emitted with tlast on 7, then IDLE, later inputs discarded.
REQ-025 RST pulsed after sample 5 of frame -> all outputs at reset values immediately; restart with EN=1 yields full frame from index 0, frame_count=1.
REQ-026 Random valid/ready, 100 frames, FRAME_LEN=16 -> scoreboard exact match, tlast every 16th, frame_count=100.

Source files
------------

// File: rtl/adc_frame_packer_if.sv
// Stream bundle between the XADC sample source, the frame packer and the FFT sink.
// A beat transfers on a rising clock edge where valid and ready are both high; a
// producer holds valid and its payload stable until that edge, and ready never waits on valid.
interface adc_frame_packer_if;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  // slave: the packer's view; master: the environment's view.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/adc_frame_packer.sv
// Packs 12-bit unipolar XADC codes into signed FFT input words, emitting only
// whole frames of FRAME_LEN samples through a 2-entry registered output FIFO.
module adc_frame_packer #(
  parameter int FRAME_LEN = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  adc_frame_packer_if.slave   bus,
  output logic [15:0]         frame_count,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    occ, occ_nxt;
  logic [32:0]   head_q, tail_q;
  logic          s_ready_q, s_ready_nxt;
  logic [15:0]   frame_cnt_q;

  logic          accept, push, pop, samp_last;
  logic [11:0]   code;
  logic [15:0]   real_part;
  logic [32:0]   entry;
  logic          unused_low;

  assign unused_low = ^bus.s_axis_tdata[3:0];

  assign accept    = bus.s_axis_tvalid & s_ready_q;
  assign push      = accept & (state != ST_IDLE);
  assign pop       = (occ != 2'd0) & bus.m_axis_tready;
  assign samp_last = (cnt == LAST_IDX);

  // Offset binary to two's complement: invert the MSB and sign-extend it.
  assign code      = bus.s_axis_tdata[15:4];
  assign real_part = {{4{~code[11]}}, ~code[11], code[10:0]};
  assign entry     = {samp_last, 16'h0000, real_part};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (EN) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (push) cnt_nxt = cnt + 1'b1;
        // Decide on the post-edge count so a frame finishing on this edge ends cleanly.
        if (!EN) state_nxt = (cnt_nxt == '0) ? ST_IDLE : ST_STOP;
      end
      ST_STOP: begin
        if (push) cnt_nxt = cnt + 1'b1;
        if (push && samp_last) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Ready is registered from the next occupancy, so the sink's ready never reaches it combinationally.
  assign s_ready_nxt = (state_nxt == ST_IDLE) || (occ_nxt != 2'd2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      occ       <= 2'd0;
      s_ready_q <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      occ       <= occ_nxt;
      s_ready_q <= s_ready_nxt;
    end
  end

  // head_q is the output register; tail_q holds the second entry when the sink stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head_q <= entry;
          else             tail_q <= entry;
        end
        2'b01: begin
          head_q <= tail_q;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= entry;
          end else begin
            head_q <= tail_q;
            tail_q <= entry;
          end
        end
        default: begin
          head_q <= head_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_cnt_q <= 16'h0000;
    end else if (pop && head_q[32]) begin
      frame_cnt_q <= frame_cnt_q + 16'h0001;
    end
  end

  assign bus.s_axis_tready = s_ready_q;
  assign bus.m_axis_tvalid = (occ != 2'd0);
  assign bus.m_axis_tdata  = head_q[31:0];
  assign bus.m_axis_tlast  = head_q[32] & (occ != 2'd0);
  assign frame_count       = frame_cnt_q;
  assign busy              = (state != ST_IDLE);
  assign state_dbg         = state;

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && occ == 2'd2));

  a_out_stable: assert property (@(posedge CLK) disable iff (RST)
    (bus.m_axis_tvalid && !bus.m_axis_tready) |=>
      (bus.m_axis_tvalid && $stable(bus.m_axis_tdata) && $stable(bus.m_axis_tlast)));

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed and randomized bench for adc_frame_packer at FRAME_LEN 8 and 16.
module tb_adc_frame_packer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic        sel16 = 1'b0;
  logic        done = 1'b0;

  adc_frame_packer_if bus8();
  adc_frame_packer_if bus16();

  assign bus8.s_axis_tdata   = s_data;
  assign bus8.s_axis_tvalid  = s_valid;
  assign bus8.m_axis_tready  = m_ready;
  assign bus16.s_axis_tdata  = s_data;
  assign bus16.s_axis_tvalid = s_valid;
  assign bus16.m_axis_tready = m_ready;

  logic [15:0] fc8, fc16;
  logic        busy8, busy16;
  logic [1:0]  st8, st16;

  adc_frame_packer #(.FRAME_LEN(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .EN(EN), .bus(bus8),
    .frame_count(fc8), .busy(busy8), .state_dbg(st8)
  );

  adc_frame_packer #(.FRAME_LEN(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .EN(EN), .bus(bus16),
    .frame_count(fc16), .busy(busy16), .state_dbg(st16)
  );

  logic        cur_ready, cur_valid, cur_last, cur_busy;
  logic [31:0] cur_data;
  logic [15:0] cur_fc;
  logic [1:0]  cur_st;

  assign cur_ready = sel16 ? bus16.s_axis_tready : bus8.s_axis_tready;
  assign cur_valid = sel16 ? bus16.m_axis_tvalid : bus8.m_axis_tvalid;
  assign cur_last  = sel16 ? bus16.m_axis_tlast  : bus8.m_axis_tlast;
  assign cur_data  = sel16 ? bus16.m_axis_tdata  : bus8.m_axis_tdata;
  assign cur_fc    = sel16 ? fc16 : fc8;
  assign cur_busy  = sel16 ? busy16 : busy8;
  assign cur_st    = sel16 ? st16 : st8;

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_re;
    logic        exp_last;
  } vec_t;

  vec_t        tbl[16];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];

  function automatic logic [32:0] ew(input logic last, input logic [15:0] re);
    return {last, 16'h0000, re};
  endfunction

  // Independent model: subtract the mid-scale offset from the 12-bit code.
  function automatic logic [15:0] conv(input logic [15:0] d);
    int v;
    v = int'(d[15:4]) - 2048;
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (!cur_ready && n < 200);
    if (!cur_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got tready=0 expected tready=1 within 200 cycles");
    end
    @(posedge CLK);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge CLK);
      if (!RST && m_ready && cur_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected no output", {cur_last, cur_data});
        end else begin
          e = exp_q.pop_front();
          check("out_word", {cur_last, cur_data}, e);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, cur_valid, 1'b0);
    check({tag, "_tdata"}, cur_data, 32'h0);
    check({tag, "_tlast"}, cur_last, 1'b0);
    check({tag, "_tready"}, cur_ready, 1'b1);
    check({tag, "_frame_count"}, cur_fc, 16'h0);
    check({tag, "_busy"}, cur_busy, 1'b0);
  endtask

  initial begin
    // Frame of codes 0..7, then a conversion sweep frame.
    for (int i = 0; i < 8; i++) begin
      tbl[i].din      = 16'(i << 4);
      tbl[i].exp_re   = 16'hF800 + 16'(i);
      tbl[i].exp_last = (i == 7);
    end
    tbl[8]  = '{16'h0000, 16'hF800, 1'b0};
    tbl[9]  = '{16'h8000, 16'h0000, 1'b0};
    tbl[10] = '{16'hFFF0, 16'h07FF, 1'b0};
    tbl[11] = '{16'h7FFF, 16'hFFFF, 1'b0};
    tbl[12] = '{16'h000F, 16'hF800, 1'b0};
    tbl[13] = '{16'h4000, 16'hFC00, 1'b0};
    tbl[14] = '{16'hC000, 16'h0400, 1'b0};
    tbl[15] = '{16'h8010, 16'h0001, 1'b1};

    fork
      monitor();
    join_none

    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    check("reset_state", cur_st, 2'd0);

    RST = 1'b0;
    m_ready = 1'b1;
    EN = 1'b1;
    @(posedge CLK);
    #1;
    check("run_busy", cur_busy, 1'b1);

    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(ew(tbl[i].exp_last, tbl[i].exp_re));
      send(tbl[i].din);
      if (i == 0) begin
        check("latency_tvalid", cur_valid, 1'b1);
        check("latency_tdata", cur_data, 32'h0000F800);
      end
      if (i == 7) begin
        drain(50);
        check("frame_count_1", cur_fc, 16'd1);
      end
    end
    drain(50);
    check("frame_count_2", cur_fc, 16'd2);

    // Sink stall mid-frame.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ew(1'b0, 16'hF810 + 16'(i)));
      send(16'((16 + i) << 4));
    end
    drain(50);
    m_ready = 1'b0;
    for (int i = 3; i < 8; i++) exp_q.push_back(ew(i == 7, 16'hF810 + 16'(i)));
    fork
      begin
        for (int i = 3; i < 8; i++) send(16'((16 + i) << 4));
      end
      begin
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 7; k++) begin
          @(negedge CLK);
          check("stall_tvalid", cur_valid, 1'b1);
          check("stall_tdata", cur_data, 32'h0000F813);
          check("stall_tready", cur_ready, 1'b0);
        end
        @(posedge CLK);
        #1;
        m_ready = 1'b1;
      end
    join
    drain(50);
    check("frame_count_3", cur_fc, 16'd3);

    // EN dropped after sample 3: frame completes in STOP, then inputs are discarded.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ew(1'b0, 16'hF820 + 16'(i)));
      send(16'((32 + i) << 4));
    end
    EN = 1'b0;
    @(posedge CLK);
    #1;
    check("stop_busy", cur_busy, 1'b1);
    check("stop_state", cur_st, 2'd2);
    for (int i = 4; i < 8; i++) begin
      if (i == 5) EN = 1'b1;
      if (i == 7) EN = 1'b0;
      exp_q.push_back(ew(i == 7, 16'hF820 + 16'(i)));
      send(16'((32 + i) << 4));
    end
    check("stop_to_idle_busy", cur_busy, 1'b0);
    for (int i = 0; i < 3; i++) send(16'h3000 + 16'(i << 4));
    drain(50);
    check("frame_count_4", cur_fc, 16'd4);
    check("idle_no_output", cur_valid, 1'b0);

    // Reset pulse mid-frame, then a clean frame from index 0.
    EN = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ew(1'b0, 16'hF830 + 16'(i)));
      send(16'((48 + i) << 4));
    end
    RST = 1'b1;
    #1;
    exp_q.delete();
    check_reset_outputs("midreset");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ew(i == 7, 16'hF840 + 16'(i)));
      send(16'((64 + i) << 4));
    end
    drain(50);
    check("restart_frame_count", cur_fc, 16'd1);

    // Random valid/ready, 100 frames of 16 on the second instance.
    sel16 = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    fork
      begin
        logic [15:0] d;
        for (int f = 0; f < 100; f++) begin
          for (int s = 0; s < 16; s++) begin
            d = 16'($urandom);
            exp_q.push_back(ew(s == 15, conv(d)));
            repeat ($urandom_range(0, 2)) begin
              @(posedge CLK);
              #1;
            end
            send(d);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK);
          #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    drain(200);
    check("random_frame_count", cur_fc, 16'd100);
    check("random_state_run", cur_st, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
